ov7670_capture: RTL and testbench

OV7670_CAPTURE -- requirements
Module: ov7670_capture

---
 rtl/cam_pkg.sv | 25 ++
 rtl/cam_byte_pair.sv | 48 ++++
 rtl/ov7670_capture.sv | 158 +++++++++++++++
 tb/tb_ov7670_capture.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// cam_pkg -- definitions shared by the OV7670 capture path and the frame-buffer users.
//   H_PIX / V_LINES : stored frame geometry (320 x 240)
//   FB_DEPTH        : frame-buffer depth in pixels (76800)
//   FB_AW           : frame-buffer address width (17)
//   cap_state_t     : capture FSM state encoding
//   rgb565_t        : one RGB565 pixel, laid out as {first byte, second byte}
package cam_pkg;

    localparam int unsigned H_PIX    = 320;
    localparam int unsigned V_LINES  = 240;
    localparam int unsigned FB_DEPTH = H_PIX * V_LINES;
    localparam int unsigned FB_AW    = 17;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        ACTIVE     = 1'b1
    } cap_state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

endpackage

// File: rtl/cam_byte_pair.sv
// cam_byte_pair -- pairs camera bytes into RGB565 pixels.
//   pclk      in   camera pixel clock (rising edge)
//   reset     in   asynchronous active-high reset
//   enable    in   capture FSM is in ACTIVE; phase is held at 0 otherwise
//   href      in   line valid; phase clears whenever it is low
//   data      in   camera byte, high byte first
//   pix_valid out  strobe (combinational) in the cycle the second byte is on data
//   pix_data  out  {latched high byte, data}, meaningful while pix_valid=1
module cam_byte_pair
    import cam_pkg::*;
(
    input  logic       pclk,
    input  logic       reset,
    input  logic       enable,
    input  logic       href,
    input  logic [7:0] data,
    output logic       pix_valid,
    output rgb565_t    pix_data
);

    logic       phase_q, phase_d;
    logic [7:0] hi_q, hi_d;

    always_comb begin
        phase_d = 1'b0;
        hi_d    = hi_q;
        if (enable && href) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                hi_d = data;
            end
        end
    end

    assign pix_valid = enable & href & phase_q;
    assign pix_data  = {hi_q, data};

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            phase_q <= 1'b0;
            hi_q    <= '0;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
        end
    end

endmodule

// File: rtl/ov7670_capture.sv
// ov7670_capture -- OV7670 RGB565 frame capture into a frame-buffer write port.
//   pclk       in   camera pixel clock (rising edge)
//   reset      in   asynchronous active-high reset
//   capture_en in   1 = capture frames; sampled only when a frame starts
//   vsync      in   vertical sync, high = frame blanking
//   href       in   line valid
//   data[7:0]  in   camera byte, RGB565 high byte first
//   we         out  frame-buffer write enable, one pclk per stored pixel
//   wAddr[16:0]out  frame-buffer write address (0 .. H_PIX*V_LINES-1)
//   wData[15:0]out  RGB565 pixel
//   frame_done out  one-pclk pulse when a captured frame ends
// Build option: define CAPTURE_DECIMATE_EN for a 640x480 camera; only even
// columns of even rows are stored, giving H_PIX x V_LINES in the same range.
module ov7670_capture #(
    parameter int unsigned H_PIX   = cam_pkg::H_PIX,
    parameter int unsigned V_LINES = cam_pkg::V_LINES
) (
    input  logic                      pclk,
    input  logic                      reset,
    input  logic                      capture_en,
    input  logic                      vsync,
    input  logic                      href,
    input  logic [7:0]                data,
    output logic                      we,
    output logic [cam_pkg::FB_AW-1:0] wAddr,
    output logic [15:0]               wData,
    output logic                      frame_done
);

    localparam int unsigned  AW    = cam_pkg::FB_AW;
    localparam logic [AW-1:0] DEPTH = AW'(H_PIX * V_LINES);

    cam_pkg::cap_state_t state_q, state_d;
    logic                vsync_q;
    logic [AW-1:0]       addr_q, addr_d;
    logic                we_q, we_d;
    logic [AW-1:0]       waddr_q, waddr_d;
    cam_pkg::rgb565_t    wdata_q, wdata_d;
    logic                frame_done_q, frame_done_d;

    logic                active;
    logic                pix_valid;
    cam_pkg::rgb565_t    pix_data;
    logic                vs_fall, vs_rise;
    logic                store;

`ifdef CAPTURE_DECIMATE_EN
    logic                col_q, col_d;
    logic                row_q, row_d;
    logic                href_q;
`endif

    assign active  = (state_q == cam_pkg::ACTIVE);
    assign vs_fall = vsync_q & ~vsync;
    assign vs_rise = ~vsync_q & vsync;

    cam_byte_pair u_byte_pair (
        .pclk      (pclk),
        .reset     (reset),
        .enable    (active),
        .href      (href),
        .data      (data),
        .pix_valid (pix_valid),
        .pix_data  (pix_data)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        frame_done_d = 1'b0;
        store        = pix_valid;
`ifdef CAPTURE_DECIMATE_EN
        col_d        = col_q;
        row_d        = row_q;
`endif
        case (state_q)
            cam_pkg::WAIT_FRAME: begin
                if (vs_fall && capture_en) begin
                    state_d = cam_pkg::ACTIVE;
                    addr_d  = '0;
`ifdef CAPTURE_DECIMATE_EN
                    col_d   = 1'b0;
                    row_d   = 1'b0;
`endif
                end
            end
            cam_pkg::ACTIVE: begin
                if (vs_rise) begin
                    state_d      = cam_pkg::WAIT_FRAME;
                    frame_done_d = 1'b1;
                    addr_d       = '0;
                end else begin
`ifdef CAPTURE_DECIMATE_EN
                    // Parity of the current column/row decides whether the pixel is kept.
                    if (pix_valid) begin
                        col_d = ~col_q;
                    end
                    if (href_q && !href) begin
                        row_d = ~row_q;
                    end
                    store = pix_valid & ~col_q & ~row_q;
`endif
                    // Address saturates at DEPTH; later pixels are dropped.
                    if (store && (addr_q < DEPTH)) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = pix_data;
                        addr_d  = addr_q + AW'(1);
                    end
                end
            end
            default: state_d = cam_pkg::WAIT_FRAME;
        endcase
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q      <= cam_pkg::WAIT_FRAME;
            vsync_q      <= 1'b1;
            addr_q       <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync;
            addr_q       <= addr_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef CAPTURE_DECIMATE_EN
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            col_q  <= 1'b0;
            row_q  <= 1'b0;
            href_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            href_q <= href;
        end
    end
`endif

    assign we         = we_q;
    assign wAddr      = waddr_q;
    assign wData      = wdata_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// tb_ov7670_capture -- directed bench for ov7670_capture on a reduced frame
// size (named parameter overrides). Inputs are driven on the falling edge of
// pclk, outputs are sampled on the falling edge. With CAPTURE_DECIMATE_EN
// defined the bench drives a double-size camera frame instead.
module tb_ov7670_capture;

`ifdef CAPTURE_DECIMATE_EN
    localparam int unsigned SH = 8;
    localparam int unsigned SV = 4;
    localparam int unsigned CH = 16;
    localparam int unsigned CV = 8;
`else
    localparam int unsigned SH = 16;
    localparam int unsigned SV = 8;
    localparam int unsigned CH = 16;
    localparam int unsigned CV = 8;
`endif
    localparam int unsigned DEPTH = SH * SV;

    logic        pclk = 1'b0;
    logic        reset;
    logic        capture_en;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        we;
    logic [16:0] wAddr;
    logic [15:0] wData;
    logic        frame_done;

    int n_vec = 0;
    int n_err = 0;

    // monitor state
    int          wr_cnt   = 0;
    int          fd_cnt   = 0;
    int          seq_err  = 0;
    int          frm_cnt  = 0;
    int          max_addr = 0;
    int          last_addr = 0;
    logic [15:0] last_data = '0;
    logic        data_chk = 1'b0;
    logic [15:0] mem [DEPTH];

    int w0, f0, e0;

    ov7670_capture #(.H_PIX(SH), .V_LINES(SV)) dut (
        .pclk       (pclk),
        .reset      (reset),
        .capture_en (capture_en),
        .vsync      (vsync),
        .href       (href),
        .data       (data),
        .we         (we),
        .wAddr      (wAddr),
        .wData      (wData),
        .frame_done (frame_done)
    );

    always #5 pclk = ~pclk;

    function automatic logic [15:0] pix_word(input int unsigned idx);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = idx[7:0];
        hi = idx[15:8];
        return {lo ^ 8'hC3 ^ hi, lo + 8'h11};
    endfunction

    function automatic logic [15:0] exp_word(input int unsigned a);
`ifdef CAPTURE_DECIMATE_EN
        return pix_word(2 * (a / SH) * CH + 2 * (a % SH));
`else
        return pix_word(a);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge pclk) begin
        if (vsync) frm_cnt = 0;
        if (frame_done) fd_cnt++;
        if (we) begin
            if (int'(wAddr) != frm_cnt) seq_err++;
            if (data_chk && (wData != exp_word(int'(wAddr)))) seq_err++;
            if (int'(wAddr) < DEPTH) mem[wAddr] = wData;
            if (int'(wAddr) > max_addr) max_addr = int'(wAddr);
            last_addr = int'(wAddr);
            last_data = wData;
            wr_cnt++;
            frm_cnt++;
        end
    end

    task automatic snap();
        w0 = wr_cnt;
        f0 = fd_cnt;
        e0 = seq_err;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge pclk);
            href = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge pclk);
        href = 1'b1;
        data = b;
    endtask

    task automatic vs_fall();
        @(negedge pclk);
        vsync = 1'b0;
        href  = 1'b0;
        idle(2);
    endtask

    task automatic vs_rise();
        @(negedge pclk);
        vsync = 1'b1;
        href  = 1'b0;
        idle(3);
    endtask

    task automatic send_line(input int unsigned row, input int unsigned npix, input int unsigned width);
        logic [15:0] w;
        for (int unsigned c = 0; c < npix; c++) begin
            w = pix_word(row * width + c);
            send_byte(w[15:8]);
            @(negedge pclk);
            data = w[7:0];
        end
        @(negedge pclk);
        href = 1'b0;
        data = '0;
        @(negedge pclk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        vsync      = 1'b1;
        href       = 1'b0;
        data       = '0;
        capture_en = 1'b1;
        repeat (3) @(negedge pclk);
        chk("rst_we", we, 0);
        chk("rst_waddr", wAddr, 0);
        chk("rst_wdata", wData, 0);
        chk("rst_fd", frame_done, 0);
        @(negedge pclk);
        reset = 1'b0;

`ifdef CAPTURE_DECIMATE_EN
        // one 2x-size camera frame
        data_chk = 1'b1;
        snap();
        vs_fall();
        for (int unsigned r = 0; r < CV; r++) send_line(r, CH, CH);
        @(negedge pclk);
        vsync = 1'b1;
        @(negedge pclk);
        chk("dec_fd_hi", frame_done, 1);
        @(negedge pclk);
        chk("dec_fd_lo", frame_done, 0);
        chk("dec_writes", wr_cnt - w0, DEPTH);
        chk("dec_last_addr", last_addr, DEPTH - 1);
        chk("dec_max_addr", max_addr, DEPTH - 1);
        chk("dec_seq", seq_err - e0, 0);
        chk("dec_fd_cnt", fd_cnt - f0, 1);
        chk("dec_pix_2_2", mem[SH + 1], pix_word(2 * CH + 2));
        chk("dec_pix_0_0", mem[0], pix_word(0));
`else
        // two pixels, exact latency
        data_chk = 1'b0;
        vs_fall();
        send_byte(8'hF8);
        @(negedge pclk);
        chk("p0_we_early", we, 0);
        data = 8'h00;
        @(negedge pclk);
        chk("p0_we", we, 1);
        chk("p0_addr", wAddr, 0);
        chk("p0_data", wData, 16'hF800);
        data = 8'h07;
        @(negedge pclk);
        chk("p1_we_early", we, 0);
        data = 8'hE0;
        @(negedge pclk);
        chk("p1_we", we, 1);
        chk("p1_addr", wAddr, 1);
        chk("p1_data", wData, 16'h07E0);
        href = 1'b0;
        @(negedge pclk);
        chk("hold_we", we, 0);
        chk("hold_addr", wAddr, 1);
        chk("hold_data", wData, 16'h07E0);
        vs_rise();

        // odd trailing byte is dropped
        snap();
        vs_fall();
        send_byte(8'hA1);
        send_byte(8'hB2);
        send_byte(8'hC3);
        idle(2);
        send_byte(8'hD4);
        send_byte(8'hE5);
        idle(2);
        chk("odd_writes", wr_cnt - w0, 2);
        chk("odd_last_addr", last_addr, 1);
        chk("odd_last_data", last_data, 16'hD4E5);
        vs_rise();

        // full frame
        data_chk = 1'b1;
        snap();
        vs_fall();
        for (int unsigned r = 0; r < SV; r++) send_line(r, SH, SH);
        @(negedge pclk);
        vsync = 1'b1;
        @(negedge pclk);
        chk("fd_hi", frame_done, 1);
        @(negedge pclk);
        chk("fd_lo", frame_done, 0);
        chk("full_writes", wr_cnt - w0, DEPTH);
        chk("full_last_addr", last_addr, DEPTH - 1);
        chk("full_seq", seq_err - e0, 0);
        chk("full_fd_cnt", fd_cnt - f0, 1);

        // next frame restarts at 0
        snap();
        vs_fall();
        send_line(0, 1, SH);
        chk("restart_writes", wr_cnt - w0, 1);
        chk("restart_addr", last_addr, 0);
        vs_rise();

        // overflow: 10 extra pixels
        snap();
        vs_fall();
        for (int unsigned r = 0; r < SV; r++) send_line(r, SH, SH);
        send_line(SV, 10, SH);
        chk("ovf_writes", wr_cnt - w0, DEPTH);
        chk("ovf_last_addr", last_addr, DEPTH - 1);
        chk("ovf_max_addr", max_addr, DEPTH - 1);
        chk("ovf_waddr", wAddr, DEPTH - 1);
        vs_rise();

        // capture disabled before frame start; vsync rise in WAIT_FRAME
        capture_en = 1'b0;
        snap();
        vs_fall();
        send_line(0, SH, SH);
        vs_rise();
        chk("dis_writes", wr_cnt - w0, 0);
        chk("dis_fd_cnt", fd_cnt - f0, 0);

        // capture_en dropped mid-frame
        capture_en = 1'b1;
        snap();
        vs_fall();
        send_line(0, SH, SH);
        capture_en = 1'b0;
        send_line(1, SH, SH);
        vs_rise();
        chk("mid_writes", wr_cnt - w0, 2 * SH);
        chk("mid_fd_cnt", fd_cnt - f0, 1);
        chk("mid_seq", seq_err - e0, 0);
        capture_en = 1'b1;

        // reset at pixel 100
        snap();
        vs_fall();
        send_line(0, 100, SH);
        chk("pre_rst_writes", wr_cnt - w0, 100);
        chk("pre_rst_addr", wAddr, 99);
        #2;
        reset = 1'b1;
        vsync = 1'b1;
        #1;
        chk("arst_we", we, 0);
        chk("arst_waddr", wAddr, 0);
        chk("arst_wdata", wData, 0);
        @(negedge pclk);
        reset = 1'b0;
        snap();
        vs_fall();
        for (int unsigned r = 0; r < SV; r++) send_line(r, SH, SH);
        vs_rise();
        chk("post_rst_writes", wr_cnt - w0, DEPTH);
        chk("post_rst_last", last_addr, DEPTH - 1);
        chk("post_rst_seq", seq_err - e0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
